// File: rtl/xcvr_bus_arbiter.sv
// Round-robin arbiter for two requesters sharing one ls245-style transceiver.
// Each transfer runs SETUP (DIR settles, OEn high), ACTIVE (OEn low), then TURN (OEn high).
module xcvr_bus_arbiter #(
    parameter int SETUP_CYC  = 1,
    parameter int ACTIVE_CYC = 2,
    parameter int TURN_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] wr,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic       latch_en,
    output logic       busy,
    output logic       xcvr_dir,
    output logic       xcvr_oen
);

    localparam int MAX_SA  = (SETUP_CYC > ACTIVE_CYC) ? SETUP_CYC : ACTIVE_CYC;
    localparam int MAX_CYC = (MAX_SA > TURN_CYC) ? MAX_SA : TURN_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] ACTIVE_LAST = CW'(ACTIVE_CYC - 1);
    localparam logic [CW-1:0] TURN_LAST   = CW'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACTIVE,
        TURN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          owner, owner_nxt;
    logic          dir_q, dir_nxt;
    logic          rr_last, rr_nxt;
    logic          win;
    logic          act_last;
    logic [1:0]    owner_oh;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            owner   <= 1'b0;
            dir_q   <= 1'b1;
            rr_last <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            owner   <= owner_nxt;
            dir_q   <= dir_nxt;
            rr_last <= rr_nxt;
        end
    end

    // DIR is only ever reloaded on the IDLE->SETUP edge, so it cannot move while OEn is low.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        dir_nxt   = dir_q;
        rr_nxt    = rr_last;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    win       = (req == 2'b11) ? ~rr_last : req[1];
                    owner_nxt = win;
                    dir_nxt   = wr[win];
                    cnt_nxt   = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ACTIVE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt == ACTIVE_LAST) begin
                    rr_nxt    = owner;
                    cnt_nxt   = '0;
                    state_nxt = TURN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            TURN: begin
                if (cnt == TURN_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode only from registered state, counter, owner and direction.
    always_comb begin
        owner_oh = owner ? 2'b10 : 2'b01;
        act_last = (state == ACTIVE) && (cnt == ACTIVE_LAST);
        gnt      = ((state == SETUP) || (state == ACTIVE)) ? owner_oh : 2'b00;
        ack      = act_last ? owner_oh : 2'b00;
        latch_en = act_last & ~dir_q;
        busy     = (state != IDLE);
        xcvr_oen = (state != ACTIVE);
        xcvr_dir = dir_q;
    end

endmodule

// File: tb/tb_xcvr_bus_arbiter.sv
// Randomized bench for xcvr_bus_arbiter against a transaction-level timing model,
// plus a directed check of a non-default parameter set on a second instance.
module tb_xcvr_bus_arbiter;

    localparam int S = 1;
    localparam int A = 2;
    localparam int T = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic [1:0] wr;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic       latch_en;
    logic       busy;
    logic       xcvr_dir;
    logic       xcvr_oen;

    logic       reset_n6;
    logic [1:0] req6;
    logic [1:0] wr6;
    logic [1:0] gnt6;
    logic [1:0] ack6;
    logic       latch_en6;
    logic       busy6;
    logic       xcvr_dir6;
    logic       xcvr_oen6;

    always #5 clk = ~clk;

    xcvr_bus_arbiter #(.SETUP_CYC(S), .ACTIVE_CYC(A), .TURN_CYC(T)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .wr       (wr),
        .gnt      (gnt),
        .ack      (ack),
        .latch_en (latch_en),
        .busy     (busy),
        .xcvr_dir (xcvr_dir),
        .xcvr_oen (xcvr_oen)
    );

    xcvr_bus_arbiter #(.SETUP_CYC(2), .ACTIVE_CYC(3), .TURN_CYC(2)) u_dut6 (
        .clk      (clk),
        .reset_n  (reset_n6),
        .req      (req6),
        .wr       (wr6),
        .gnt      (gnt6),
        .ack      (ack6),
        .latch_en (latch_en6),
        .busy     (busy6),
        .xcvr_dir (xcvr_dir6),
        .xcvr_oen (xcvr_oen6)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: a transfer is "edges since grant" k; everything follows from S/A/T arithmetic.
    bit m_busy  = 1'b0;
    int m_k     = 0;
    bit m_owner = 1'b0;
    bit m_dir   = 1'b1;
    bit m_rr    = 1'b1;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void modelStep(input logic rn, input logic [1:0] r, input logic [1:0] w);
        if (!rn) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_rr   = 1'b1;
            m_dir  = 1'b1;
        end else if (m_busy) begin
            m_k++;
            if (m_k == S + A)     m_rr   = m_owner;
            if (m_k == S + A + T) m_busy = 1'b0;
        end else if (r != 2'b00) begin
            m_owner = (r == 2'b11) ? ~m_rr : r[1];
            m_dir   = w[m_owner];
            m_busy  = 1'b1;
            m_k     = 0;
        end
    endfunction

    task automatic compareAll();
        logic [1:0] oh;
        bit in_grant, in_act, at_ack;
        oh       = m_owner ? 2'b10 : 2'b01;
        in_grant = m_busy && (m_k <= S + A - 1);
        in_act   = m_busy && (m_k >= S) && (m_k <= S + A - 1);
        at_ack   = m_busy && (m_k == S + A - 1);
        checkOutput("gnt",      8'(gnt),      8'(in_grant ? oh : 2'b00));
        checkOutput("ack",      8'(ack),      8'(at_ack ? oh : 2'b00));
        checkOutput("latch_en", 8'(latch_en), 8'(at_ack && !m_dir));
        checkOutput("busy",     8'(busy),     8'(m_busy));
        checkOutput("xcvr_oen", 8'(xcvr_oen), 8'(!in_act));
        checkOutput("xcvr_dir", 8'(xcvr_dir), 8'(m_dir));
    endtask

    task automatic applyStimulus(input logic rn, input logic [1:0] r, input logic [1:0] w);
        @(negedge clk);
        reset_n = rn;
        req     = r;
        wr      = w;
        @(posedge clk);
        modelStep(rn, r, w);
        #1;
        compareAll();
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 2'b00;
        wr       = 2'b00;
        reset_n6 = 1'b0;
        req6     = 2'b00;
        wr6      = 2'b01;

        // Wider timing parameters on the second instance: edges counted from grant edge 0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n6 = 1'b1;
        req6     = 2'b01;
        for (int e = 0; e <= 8; e++) begin
            @(posedge clk);
            #1;
            checkOutput("p6_oen",  8'(xcvr_oen6), 8'(!(e >= 2 && e <= 4)));
            checkOutput("p6_ack",  8'(ack6),      8'((e == 4) ? 2'b01 : 2'b00));
            checkOutput("p6_gnt",  8'(gnt6),      8'((e <= 4) ? 2'b01 : 2'b00));
            checkOutput("p6_busy", 8'(busy6),     8'(e <= 6));
            checkOutput("p6_dir",  8'(xcvr_dir6), 8'(1'b1));
            @(negedge clk);
            if (e == 4) req6 = 2'b00;
        end

        // Reset state, then single A->B and B->A transfers.
        repeat (2) applyStimulus(1'b0, 2'b00, 2'b00);
        repeat (3) applyStimulus(1'b1, 2'b01, 2'b01);
        repeat (3) applyStimulus(1'b1, 2'b00, 2'b01);
        repeat (3) applyStimulus(1'b1, 2'b10, 2'b00);
        repeat (3) applyStimulus(1'b1, 2'b00, 2'b00);

        // Both requesting continuously: grants alternate, DIR follows each owner.
        repeat (20) applyStimulus(1'b1, 2'b11, 2'b01);
        repeat (4) applyStimulus(1'b1, 2'b00, 2'b01);

        // Reset while ACTIVE, then a fresh transfer.
        repeat (2) applyStimulus(1'b1, 2'b01, 2'b01);
        applyStimulus(1'b0, 2'b01, 2'b01);
        repeat (5) applyStimulus(1'b1, 2'b01, 2'b01);
        repeat (2) applyStimulus(1'b1, 2'b00, 2'b00);

        // Request dropped after edge 1, direction flipped mid-transfer.
        repeat (2) applyStimulus(1'b1, 2'b01, 2'b00);
        repeat (4) applyStimulus(1'b1, 2'b00, 2'b11);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 59) != 0), 2'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
